// File: rtl/enemy_palette_arbiter.sv
// enemy_palette_arbiter: round-robin share of one palette lookup across sprite pipelines, registered RGB out
module enemy_palette_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = 2,
  parameter int KEY_INDEX = 0
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [3*NUM_REQ-1:0] req_idx,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [2:0]           pal_index,
  input  logic [11:0]          pal_rgb,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [11:0]          out_rgb,
  output logic [ID_W-1:0]      out_id,
  output logic                 out_transparent
);
  logic [ID_W-1:0] rr, win;
  logic found, grant, slot_free;
  assign slot_free = !out_valid || out_ready;
  // lowest requester at or above rr wins; otherwise wrap to the lowest overall
  always_comb begin
    win = '0;
    found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req[i]) begin
        win = ID_W'(i);
        found = 1'b1;
      end
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req[i] && ID_W'(i) >= rr) win = ID_W'(i);
  end
  assign grant     = found && slot_free && !Reset;
  assign gnt       = grant ? NUM_REQ'(1) << win : '0;
  assign pal_index = grant ? req_idx[3*win +: 3] : 3'd0;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      out_valid       <= 1'b0;
      out_rgb         <= '0;
      out_id          <= '0;
      out_transparent <= 1'b0;
      rr              <= '0;
    end else if (grant) begin
      out_valid       <= 1'b1;
      out_rgb         <= pal_rgb;
      out_id          <= win;
      out_transparent <= pal_index == 3'(KEY_INDEX);
      rr              <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_enemy_palette_arbiter.sv
// tb_enemy_palette_arbiter: randomized scoreboard bench against a round-robin reference model
module tb_enemy_palette_arbiter;
  logic        Clk = 1'b0, Reset = 1'b1;
  logic [3:0]  req = '0;
  logic [11:0] req_idx = '0;
  logic [3:0]  gnt;
  logic [2:0]  pal_index;
  logic [11:0] pal_rgb;
  logic        out_valid, out_ready = 1'b0;
  logic [11:0] out_rgb;
  logic [1:0]  out_id;
  logic        out_transparent;
  logic [11:0] pal [8];
  logic [14:0] q[$];
  logic [14:0] held;
  int checks = 0, errors = 0, rr = 0;
  bit mv = 1'b0, run = 1'b0, stall_prev = 1'b0;

  enemy_palette_arbiter dut (
    .Clk(Clk), .Reset(Reset), .req(req), .req_idx(req_idx), .gnt(gnt),
    .pal_index(pal_index), .pal_rgb(pal_rgb), .out_valid(out_valid), .out_ready(out_ready),
    .out_rgb(out_rgb), .out_id(out_id), .out_transparent(out_transparent)
  );

  always #5 Clk = ~Clk;
  assign pal_rgb = pal[pal_index];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // one cycle: drive, check combinational grant at negedge, advance model at the edge
  task automatic step(input logic [3:0] r, input logic [11:0] ix, input logic rd, input logic rs);
    int w = -1;
    logic [3:0] eg;
    logic [2:0] ei;
    req = r; req_idx = ix; out_ready = rd; Reset = rs;
    @(negedge Clk);
    if (!rs && (!mv || rd))
      for (int k = 0; k < 4; k++) begin
        int j = (rr + k) % 4;
        if (w < 0 && r[j]) w = j;
      end
    eg = (w >= 0) ? 4'(1 << w) : 4'd0;
    ei = (w >= 0) ? 3'((ix >> (3 * w)) & 7) : 3'd0;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("pal_index", 32'(pal_index), 32'(ei));
    if (w >= 0) q.push_back({pal[ei], 2'(w), ei == 3'd0});
    @(posedge Clk);
    if (rs) begin
      mv = 1'b0; rr = 0; q.delete();
    end else if (w >= 0) begin
      mv = 1'b1; rr = (w + 1) % 4;
    end else if (rd) mv = 1'b0;
    #1;
  endtask

  always @(negedge Clk) if (run) begin
    chk("out_valid", 32'(out_valid), 32'(mv));
    if (stall_prev) chk("stall_hold", 32'({out_rgb, out_id, out_transparent}), 32'(held));
    if (out_valid && !Reset) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL pixel: got %h expected none", {out_rgb, out_id, out_transparent});
      end else begin
        chk("pixel", 32'({out_rgb, out_id, out_transparent}), 32'(q[0]));
        if (out_ready) void'(q.pop_front());
      end
    end
    stall_prev = out_valid && !out_ready && !Reset;
    held = {out_rgb, out_id, out_transparent};
  end

  initial begin
    for (int i = 0; i < 8; i++) pal[i] = 12'($urandom);
    pal[0] = 12'h0E0;
    pal[5] = 12'hC20;
    step(4'b0000, 12'h0, 1'b1, 1'b1);
    step(4'b0000, 12'h0, 1'b1, 1'b1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_rgb", 32'(out_rgb), 0);
    chk("rst_out_id", 32'(out_id), 0);
    chk("rst_out_transparent", 32'(out_transparent), 0);
    run = 1'b1;
    repeat (5) step(4'b1111, 12'(6'o77), 1'b1, 1'b0);
    step(4'b0000, 12'h0, 1'b1, 1'b0);
    step(4'b0100, 12'(5) << 6, 1'b1, 1'b0);
    step(4'b0000, 12'h0, 1'b1, 1'b0);
    step(4'b0001, 12'h0, 1'b1, 1'b0);
    step(4'b0000, 12'h0, 1'b1, 1'b0);
    step(4'b0001, 12'h3, 1'b1, 1'b0);
    repeat (5) step(4'b1111, 12'($urandom), 1'b0, 1'b0);
    repeat (3) step(4'b1111, 12'($urandom), 1'b1, 1'b0);
    step(4'b0000, 12'h0, 1'b1, 1'b1);
    repeat (4) step(4'b1010, 12'($urandom), 1'b1, 1'b0);
    step(4'b1111, 12'h0, 1'b0, 1'b0);
    step(4'b1111, 12'h0, 1'b0, 1'b1);
    step(4'b1001, 12'h0, 1'b1, 1'b0);
    repeat (3000)
      step(4'($urandom), 12'($urandom), $urandom_range(3) != 0, $urandom_range(99) == 0);
    repeat (3) step(4'b0000, 12'h0, 1'b1, 1'b0);
    chk("queue_drained", 32'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
